store_buffer_lsu: RTL and testbench

Load/store unit between the execute stage and the data memory. Accepts one load or store request per cycle over a valid/ready handshake and posts stores into a 4-entry in-order write buffer. The buffer drains to memory on cycles the memory port is otherwise idle. Loads are served by store-to-load forwarding from the buffer when possible, otherwise by a single memory read whose result is captured and returned with a one-cycle response pulse.

---
 rtl/store_buffer_lsu.sv | 147 ++++++++++++++
 tb/tb_store_buffer_lsu.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_lsu.sv
// Load/store unit with a DEPTH-entry in-order store buffer that drains into data memory
// on idle memory-port cycles, with youngest-entry store-to-load forwarding.
module store_buffer_lsu #(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   resp_valid,
    output logic [31:0]            resp_data,
    output logic [$clog2(DEPTH):0] buf_count,
    output logic                   mem_write,
    output logic                   mem_read,
    output logic [31:0]            mem_daddress,
    output logic [31:0]            mem_din,
    input  logic [31:0]            mem_dout,
    output logic                   dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic {
        IDLE       = 1'b0,
        LOAD_ISSUE = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [31:0] buf_addr [DEPTH];
    logic [31:0] buf_data [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0] count;
    logic [31:0] ld_addr;
    logic        accept, push, pop;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    // Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1;
    // req_ready is a function of registered state and reset only, never of req_valid.
    assign req_ready = (state == IDLE) && (count < FULL) && !reset;
    assign accept    = req_valid && req_ready;
    assign push      = accept && req_write;
    assign buf_count = count;
    assign dbg_state = (state == LOAD_ISSUE);

    // Scan oldest to youngest so the last match (youngest store) wins; the head being drained still counts.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((PW+1)'(i) < count) && (buf_addr[head + PW'(i)] == req_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data[head + PW'(i)];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Memory port decodes only from registered state; a pending load read blocks draining.
    always_comb begin
        state_nx     = state;
        mem_write    = 1'b0;
        mem_read     = 1'b0;
        mem_daddress = 32'd0;
        mem_din      = 32'd0;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    mem_write    = 1'b1;
                    mem_daddress = buf_addr[head];
                    mem_din      = buf_data[head];
                    pop          = 1'b1;
                end
                if (accept && !req_write && !fwd_hit) begin
                    state_nx = LOAD_ISSUE;
                end
            end
            LOAD_ISSUE: begin
                mem_read     = 1'b1;
                mem_daddress = ld_addr;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            buf_addr[tail] <= req_addr;
            buf_data[tail] <= req_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            ld_addr    <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            if (state == LOAD_ISSUE) begin
                resp_valid <= 1'b1;
                resp_data  <= mem_dout;
            end else if (accept && !req_write) begin
                if (fwd_hit) begin
                    resp_valid <= 1'b1;
                    resp_data  <= fwd_data;
                end else begin
                    ld_addr <= req_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_store_buffer_lsu.sv
// Bench for store_buffer_lsu: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized load/store traffic.
module tb_store_buffer_lsu;

    localparam int DEPTH = 4;

    logic        clock, reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [2:0]  buf_count;
    logic        mem_write, mem_read;
    logic [31:0] mem_daddress, mem_din, mem_dout;
    logic        dbg_state;

    store_buffer_lsu #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .buf_count(buf_count),
        .mem_write(mem_write), .mem_read(mem_read), .mem_daddress(mem_daddress),
        .mem_din(mem_din), .mem_dout(mem_dout), .dbg_state(dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment memory seen by the DUT, and the reference memory the model expects.
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : 32'd0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
    endfunction

    always @(negedge clock) begin
        if (mem_read === 1'b1) mem_dout <= env_rd(mem_daddress);
    end

    always @(posedge clock) begin
        if (!reset && mem_write === 1'b1) env_mem[mem_daddress] = mem_din;
    end

    // Reference model: pending stores as a plain queue, plus an outstanding-miss flag.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        sq[$];
    logic [31:0] exp_q[$];
    bit          m_miss = 1'b0;
    logic [31:0] m_miss_addr = 32'd0;
    bit          m_rv = 1'b0;
    logic [31:0] m_rd = 32'd0;

    always @(posedge clock or posedge reset) begin : model_upd
        bit acc, pop, hit;
        logic [31:0] fv;
        if (reset) begin
            sq.delete();
            exp_q.delete();
            m_miss = 1'b0;
            m_rv   = 1'b0;
            m_rd   = 32'd0;
        end else begin
            acc  = req_valid && !m_miss && (sq.size() < DEPTH);
            pop  = !m_miss && (sq.size() > 0);
            m_rv = 1'b0;
            if (m_miss) begin
                m_rv   = 1'b1;
                m_rd   = ref_rd(m_miss_addr);
                m_miss = 1'b0;
            end else if (acc && !req_write) begin
                hit = 1'b0;
                fv  = 32'd0;
                for (int i = sq.size() - 1; i >= 0; i--) begin
                    if (!hit && sq[i].a == req_addr) begin
                        hit = 1'b1;
                        fv  = sq[i].d;
                    end
                end
                if (hit) begin
                    m_rv = 1'b1;
                    m_rd = fv;
                end else begin
                    m_miss      = 1'b1;
                    m_miss_addr = req_addr;
                end
            end
            if (pop) begin
                ref_mem[sq[0].a] = sq[0].d;
                void'(sq.pop_front());
            end
            if (acc && req_write) begin
                sq.push_back({req_addr, req_wdata});
                exp_q.push_back(req_wdata);
            end
        end
    end

    always @(negedge clock) begin : compare
        bit          e_wr;
        logic [31:0] e_addr, e_din;
        e_wr   = !m_miss && (sq.size() > 0);
        e_addr = m_miss ? m_miss_addr : (e_wr ? sq[0].a : 32'd0);
        e_din  = e_wr ? sq[0].d : 32'd0;
        chk("req_ready", {31'd0, req_ready}, {31'd0, !reset && !m_miss && (sq.size() < DEPTH)});
        chk("buf_count", {29'd0, buf_count}, 32'(sq.size()));
        chk("mem_write", {31'd0, mem_write}, {31'd0, e_wr});
        chk("mem_read", {31'd0, mem_read}, {31'd0, m_miss});
        chk("mem_daddress", mem_daddress, e_addr);
        chk("mem_din", mem_din, e_din);
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_rv});
        chk("resp_data", resp_data, m_rd);
        if (!reset && mem_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wr_order: got write %h expected no write at %0t", mem_din, $time);
            end else begin
                chk("wr_order", mem_din, exp_q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
    endtask

    // Offer one request and hold it until accepted (bounded).
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            n++;
            @(negedge clock);
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got req_ready 0 expected 1 within 20 cycles at %0t", $time);
        end
        @(posedge clock);
        #1;
        idle_inputs();
    endtask

    initial begin
        logic [31:0] v;
        mem_dout = 32'd0;
        idle_inputs();
        reset = 1'b1;
        for (int a = 0; a < 8; a++) begin
            v = (a == 1) ? 32'd1 : $urandom;
            env_mem[a] = v;
            ref_mem[a] = v;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_count", {29'd0, buf_count}, 32'd0);
        #2 reset = 1'b0;

        // Reset then idle.
        @(negedge clock);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("idle_resp_data", resp_data, 32'd0);
        chk("idle_mem_strobes", {30'd0, mem_write, mem_read}, 32'd0);
        chk("idle_mem_addr", mem_daddress, 32'd0);

        // Single store drains one cycle after acceptance.
        send(1'b1, 32'd5, 32'h55);
        @(negedge clock);
        chk("st_mem_write", {31'd0, mem_write}, 32'd1);
        chk("st_mem_addr", mem_daddress, 32'd5);
        chk("st_mem_din", mem_din, 32'h55);
        chk("st_count1", {29'd0, buf_count}, 32'd1);
        @(negedge clock);
        chk("st_count0", {29'd0, buf_count}, 32'd0);

        // Two stores to one address, then a forwarded load returns the younger value.
        send(1'b1, 32'd6, 32'hA);
        send(1'b1, 32'd6, 32'hB);
        send(1'b0, 32'd6, 32'd0);
        @(negedge clock);
        chk("fwd_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("fwd_resp_data", resp_data, 32'hB);
        chk("fwd_no_read", {31'd0, mem_read}, 32'd0);

        // Load miss from an empty buffer.
        repeat (3) @(negedge clock);
        send(1'b0, 32'd1, 32'd0);
        @(negedge clock);
        chk("miss_read", {31'd0, mem_read}, 32'd1);
        chk("miss_addr", mem_daddress, 32'd1);
        chk("miss_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clock);
        chk("miss_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("miss_resp_data", resp_data, 32'd1);

        // Five back-to-back stores all reach memory.
        for (int i = 0; i < 5; i++) send(1'b1, 32'h100 + 32'(i), 32'hC0 + 32'(i));
        repeat (4) @(negedge clock);
        for (int i = 0; i < 5; i++) chk("burst_mem", env_rd(32'h100 + 32'(i)), 32'hC0 + 32'(i));

        // Reset during an outstanding load miss.
        for (int i = 0; i < 3; i++) send(1'b1, 32'h20 + 32'(i), 32'hD0 + 32'(i));
        send(1'b0, 32'h30, 32'd0);
        #1 chk("rst_mid_read", {31'd0, mem_read}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_count", {29'd0, buf_count}, 32'd0);
        chk("rst_mid_strobes", {30'd0, mem_write, mem_read}, 32'd0);
        chk("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("post_rst_resp", {31'd0, resp_valid}, 32'd0);
            chk("post_rst_write", {31'd0, mem_write}, 32'd0);
        end

        // Randomized traffic over a small address window to exercise forwarding.
        @(posedge clock);
        #1;
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = $urandom_range(0, 1) == 1;
            req_addr  = 32'($urandom_range(0, 7));
            req_wdata = $urandom;
            @(posedge clock);
            #1;
        end
        idle_inputs();
        repeat (4) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

endmodule
